// File: rtl/tick_receiver.sv
// Synchronises slow clocks/strobes into clk, edge-detects them and emits prescaled one-cycle
// tick enables, with a wrapping tick counter and a stall flag per channel.
module tick_receiver #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TMO_W       = 28,
  parameter int TIMEOUT     = 200000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       slow_in,
  input  logic [NUM_CH-1:0]       edge_sel,
  input  logic [NUM_CH*CNT_W-1:0] div_m,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*CNT_W-1:0] tick_count,
  output logic [NUM_CH-1:0]       stalled
);

  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int ARM_W = $clog2(ARM_N + 1);

  logic [ARM_W-1:0] arm_cnt_reg;
  logic             armed;

  // Detection stays off until the synchronisers have flushed the reset zeros, so a level
  // already present on slow_in is absorbed into the history instead of looking like an edge.
  assign armed = (arm_cnt_reg == ARM_W'(ARM_N));

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt_reg <= '0;
    end else if (!armed) begin
      arm_cnt_reg <= arm_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   hist_reg;
      logic                   sync_last;
      logic                   edge_det;
      logic [CNT_W-1:0]       div_val;
      logic [CNT_W-1:0]       last_ec;
      logic [CNT_W-1:0]       ec_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   tick_reg;
      logic [TMO_W-1:0]       timer_reg;
      logic                   stalled_reg;

      assign sync_last = sync_reg[SYNC_STAGES-1];
      assign edge_det  = armed && (edge_sel[gi] ? (!sync_last && hist_reg)
                                                : (sync_last && !hist_reg));
      assign div_val   = div_m[gi*CNT_W +: CNT_W];
      assign last_ec   = (div_val == '0) ? '0 : div_val - 1'b1;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '0;
          hist_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], slow_in[gi]};
          hist_reg <= sync_last;
        end
      end

      // Prescaler: ">=" lets a lowered div_m take effect on the very next edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          ec_reg   <= '0;
          tick_reg <= 1'b0;
          cnt_reg  <= '0;
        end else if (edge_det && (ec_reg >= last_ec)) begin
          ec_reg   <= '0;
          tick_reg <= 1'b1;
          cnt_reg  <= cnt_reg + 1'b1;
        end else begin
          tick_reg <= 1'b0;
          if (edge_det) begin
            ec_reg <= ec_reg + 1'b1;
          end
        end
      end

      // Stall timer watches raw detected edges and saturates at TIMEOUT-1.
      always_ff @(posedge clk) begin
        if (rst || !armed) begin
          timer_reg   <= '0;
          stalled_reg <= 1'b0;
        end else if (edge_det) begin
          timer_reg   <= '0;
          stalled_reg <= 1'b0;
        end else if (timer_reg == TMO_W'(TIMEOUT - 1)) begin
          stalled_reg <= 1'b1;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end

      assign tick[gi]                     = tick_reg;
      assign tick_count[gi*CNT_W +: CNT_W] = cnt_reg;
      assign stalled[gi]                  = stalled_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tick_receiver.sv
// Directed bench for tick_receiver: 2 channels, 4-bit counters and a 50-cycle stall timeout.
module tb_tick_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] slow_in;
  logic [1:0] edge_sel;
  logic [7:0] div_m;
  logic [1:0] tick;
  logic [7:0] tick_count;
  logic [1:0] stalled;

  int vectors = 0;
  int miscompares = 0;
  int nt0 = 0;
  int nt1 = 0;
  int base;

  always #5 clk = ~clk;

  tick_receiver #(
    .NUM_CH(2), .SYNC_STAGES(2), .CNT_W(4), .TMO_W(8), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .slow_in(slow_in), .edge_sel(edge_sel), .div_m(div_m),
    .tick(tick), .tick_count(tick_count), .stalled(stalled)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tick[0] === 1'b1) nt0++;
      if (tick[1] === 1'b1) nt1++;
    end
  endtask

  // One low-then-high cycle on a channel: a falling edge followed by a rising edge.
  task automatic pulse(input int ch);
    slow_in[ch] = 1'b0;
    steps(4);
    slow_in[ch] = 1'b1;
    steps(4);
  endtask

  initial begin
    rst = 1'b1; slow_in = 2'b11; edge_sel = 2'b00; div_m = 8'h11;
    steps(2);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_count", 32'(tick_count), 32'h0);
    check("rst_stalled", 32'(stalled), 32'h0);

    // Levels held high through reset never produce a tick.
    rst = 1'b0;
    steps(40);
    check("hold_no_tick", 32'(nt0 + nt1), 32'h0);
    check("hold_count", 32'(tick_count), 32'h0);
    check("hold_stalled", 32'(stalled), 32'h0);

    // First armed edge is the 4th after release; stall lands on the 50th armed edge.
    steps(12);
    check("stall_before", 32'(stalled), 32'h0);
    steps(1);
    check("stall_assert", 32'(stalled), 32'h3);
    steps(5);
    check("stall_hold", 32'(stalled), 32'h3);
    slow_in[0] = 1'b0;
    steps(5);
    check("stall_fall_ignored", 32'(stalled), 32'h3);
    slow_in[0] = 1'b1;
    steps(2);
    check("lat_tick_early", 32'(tick), 32'h0);
    steps(1);
    check("lat_tick", 32'(tick), 32'h1);
    check("stall_clear", 32'(stalled), 32'h2);
    check("lat_count", 32'(tick_count[3:0]), 32'h1);

    // ch0 toggling every 10 cycles, div_m=1.
    for (int k = 0; k < 4; k++) begin
      slow_in[0] = 1'b0;
      steps(10);
      slow_in[0] = 1'b1;
      steps(2);
      check("tog_pre", 32'(tick[0]), 32'h0);
      steps(1);
      check("tog_tick", 32'(tick[0]), 32'h1);
      check("tog_count", 32'(tick_count[3:0]), 32'(k + 2));
      steps(1);
      check("tog_post", 32'(tick[0]), 32'h0);
      steps(6);
    end

    // Counter wrap at 4 bits: 5 -> 15 -> 0 -> 1.
    base = nt0;
    for (int k = 0; k < 10; k++) pulse(0);
    check("wrap_ticks", 32'(nt0 - base), 32'd10);
    check("wrap_15", 32'(tick_count[3:0]), 32'hf);
    pulse(0);
    check("wrap_0", 32'(tick_count[3:0]), 32'h0);
    pulse(0);
    check("wrap_1", 32'(tick_count[3:0]), 32'h1);

    // ch1 falling edges, div_m=3: ticks on edges 3, 6, 9 only.
    div_m[7:4] = 4'd3; edge_sel[1] = 1'b1;
    steps(2);
    for (int e = 1; e <= 9; e++) begin
      base = nt1;
      pulse(1);
      check("div3_edge", 32'(nt1 - base), (e % 3 == 0) ? 32'd1 : 32'd0);
    end
    check("div3_count", 32'(tick_count[7:4]), 32'h3);
    div_m[7:4] = 4'd0;
    for (int e = 1; e <= 3; e++) begin
      base = nt1;
      pulse(1);
      check("div0_edge", 32'(nt1 - base), 32'd1);
    end
    check("div0_count", 32'(tick_count[7:4]), 32'h6);

    // Partial prescale count is lost across reset.
    div_m[3:0] = 4'd3;
    base = nt0;
    pulse(0);
    pulse(0);
    check("pre_rst_none", 32'(nt0 - base), 32'd0);
    rst = 1'b1;
    steps(1);
    check("mid_rst_count", 32'(tick_count), 32'h0);
    check("mid_rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    steps(5);
    for (int e = 1; e <= 3; e++) begin
      base = nt0;
      pulse(0);
      check("post_rst_edge", 32'(nt0 - base), (e == 3) ? 32'd1 : 32'd0);
    end
    check("post_rst_count", 32'(tick_count[3:0]), 32'h1);

    // Simultaneous rising edges on both channels tick together.
    div_m = 8'h11; edge_sel = 2'b00;
    slow_in = 2'b00;
    steps(4);
    slow_in = 2'b11;
    steps(2);
    check("sim_pre", 32'(tick), 32'h0);
    steps(1);
    check("sim_tick", 32'(tick), 32'h3);
    steps(1);
    check("sim_post", 32'(tick), 32'h0);
    check("sim_count", 32'(tick_count), 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
